// File: rtl/id_ex_register.sv
// ID/EX pipeline register: carries decoded control, operands and register indices into execute.
// Handles stall, flush and invalid-decode bubbles, and keeps saturating bubble/stall counters.
module id_ex_register #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic                  JALRInstrD,
  input  logic [3:0]            ALUControlD,
  input  logic                  ALUSrcD,
  input  logic [2:0]            AddressingControlD,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] ImmExtD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            RdD,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  JALRInstrE,
  output logic [3:0]            ALUControlE,
  output logic                  ALUSrcE,
  output logic [2:0]            AddressingControlE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [4:0]            RdE,
  output logic                  ValidE,
  output logic [31:0]           BubbleCountE,
  output logic [31:0]           StallCountE
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Reset and flush both leave a full bubble, so they share one branch; flush beats stall.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE          <= 1'b0;
      ResultSrcE         <= 2'b00;
      MemWriteE          <= 1'b0;
      JumpE              <= 1'b0;
      BranchE            <= 1'b0;
      JALRInstrE         <= 1'b0;
      ALUControlE        <= 4'b0000;
      ALUSrcE            <= 1'b0;
      AddressingControlE <= 3'b000;
      RD1E               <= '0;
      RD2E               <= '0;
      PCE                <= '0;
      ImmExtE            <= '0;
      PCPlus4E           <= '0;
      Rs1E               <= 5'd0;
      Rs2E               <= 5'd0;
      RdE                <= 5'd0;
      ValidE             <= 1'b0;
    end else if (!StallE) begin
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      PCE      <= PCD;
      ImmExtE  <= ImmExtD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      ValidE   <= ValidD;
      // An invalid decode slot must not carry any side-effecting control into execute.
      if (ValidD) begin
        RegWriteE          <= RegWriteD;
        ResultSrcE         <= ResultSrcD;
        MemWriteE          <= MemWriteD;
        JumpE              <= JumpD;
        BranchE            <= BranchD;
        JALRInstrE         <= JALRInstrD;
        ALUControlE        <= ALUControlD;
        ALUSrcE            <= ALUSrcD;
        AddressingControlE <= AddressingControlD;
        RdE                <= RdD;
      end else begin
        RegWriteE          <= 1'b0;
        ResultSrcE         <= 2'b00;
        MemWriteE          <= 1'b0;
        JumpE              <= 1'b0;
        BranchE            <= 1'b0;
        JALRInstrE         <= 1'b0;
        ALUControlE        <= 4'b0000;
        ALUSrcE            <= 1'b0;
        AddressingControlE <= 3'b000;
        RdE                <= 5'd0;
      end
    end
  end

  // A stalled edge that is also flushed counts only as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      BubbleCountE <= 32'd0;
      StallCountE  <= 32'd0;
    end else if (FlushE) begin
      if (BubbleCountE != CNT_MAX) BubbleCountE <= BubbleCountE + 32'd1;
    end else if (StallE) begin
      if (StallCountE != CNT_MAX) StallCountE <= StallCountE + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: a reference model predicts each edge's E-side state,
// the prediction is queued when stimulus is driven and popped after the edge for comparison.
module tb_id_ex_register;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        jalr;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic [2:0]  addr_ctrl;
    logic [31:0] rd1, rd2, pc, imm, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        valid;
  } d_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        jalr;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic [2:0]  addr_ctrl;
    logic [31:0] rd1, rd2, pc, imm, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        valid;
    logic [31:0] bub, stl;
  } e_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  d_t   d_in = '0;

  logic        e_reg_write, e_mem_write, e_jump, e_branch, e_jalr, e_alu_src, e_valid;
  logic [1:0]  e_result_src;
  logic [3:0]  e_alu_control;
  logic [2:0]  e_addr_ctrl;
  logic [31:0] e_rd1, e_rd2, e_pc, e_imm, e_pc4, e_bub, e_stl;
  logic [4:0]  e_rs1, e_rs2, e_rd;

  int errors = 0;
  int checks = 0;
  e_t mdl = '0;
  e_t sb[$];
  e_t exp_e;
  e_t got_e;
  e_t held;

  always #5 clk = ~clk;

  id_ex_register #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .StallE(stall), .FlushE(flush), .ValidD(d_in.valid),
    .RegWriteD(d_in.reg_write), .ResultSrcD(d_in.result_src), .MemWriteD(d_in.mem_write),
    .JumpD(d_in.jump), .BranchD(d_in.branch), .JALRInstrD(d_in.jalr),
    .ALUControlD(d_in.alu_control), .ALUSrcD(d_in.alu_src), .AddressingControlD(d_in.addr_ctrl),
    .RD1D(d_in.rd1), .RD2D(d_in.rd2), .PCD(d_in.pc), .ImmExtD(d_in.imm), .PCPlus4D(d_in.pc4),
    .Rs1D(d_in.rs1), .Rs2D(d_in.rs2), .RdD(d_in.rd),
    .RegWriteE(e_reg_write), .ResultSrcE(e_result_src), .MemWriteE(e_mem_write),
    .JumpE(e_jump), .BranchE(e_branch), .JALRInstrE(e_jalr),
    .ALUControlE(e_alu_control), .ALUSrcE(e_alu_src), .AddressingControlE(e_addr_ctrl),
    .RD1E(e_rd1), .RD2E(e_rd2), .PCE(e_pc), .ImmExtE(e_imm), .PCPlus4E(e_pc4),
    .Rs1E(e_rs1), .Rs2E(e_rs2), .RdE(e_rd), .ValidE(e_valid),
    .BubbleCountE(e_bub), .StallCountE(e_stl)
  );

  function automatic e_t sample();
    e_t s;
    s.reg_write = e_reg_write;   s.result_src = e_result_src; s.mem_write = e_mem_write;
    s.jump = e_jump;             s.branch = e_branch;         s.jalr = e_jalr;
    s.alu_control = e_alu_control; s.alu_src = e_alu_src;     s.addr_ctrl = e_addr_ctrl;
    s.rd1 = e_rd1; s.rd2 = e_rd2; s.pc = e_pc; s.imm = e_imm; s.pc4 = e_pc4;
    s.rs1 = e_rs1; s.rs2 = e_rs2; s.rd = e_rd; s.valid = e_valid;
    s.bub = e_bub; s.stl = e_stl;
    return s;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Reference behaviour: reset > flush > stall > load; invalid decode yields a control bubble.
  function automatic e_t model_next(input e_t cur, input logic r, input logic s, input logic f,
                                    input d_t d);
    e_t n;
    n = cur;
    if (r) begin
      n = '0;
    end else if (f) begin
      n = '0;
      n.bub = sat_inc(cur.bub);
      n.stl = cur.stl;
    end else if (s) begin
      n.stl = sat_inc(cur.stl);
    end else begin
      n.rd1 = d.rd1; n.rd2 = d.rd2; n.pc = d.pc; n.imm = d.imm; n.pc4 = d.pc4;
      n.rs1 = d.rs1; n.rs2 = d.rs2; n.valid = d.valid;
      if (d.valid) begin
        n.reg_write = d.reg_write; n.result_src = d.result_src; n.mem_write = d.mem_write;
        n.jump = d.jump; n.branch = d.branch; n.jalr = d.jalr;
        n.alu_control = d.alu_control; n.alu_src = d.alu_src; n.addr_ctrl = d.addr_ctrl;
        n.rd = d.rd;
      end else begin
        n.reg_write = 1'b0; n.result_src = 2'b00; n.mem_write = 1'b0;
        n.jump = 1'b0; n.branch = 1'b0; n.jalr = 1'b0;
        n.alu_control = 4'b0000; n.alu_src = 1'b0; n.addr_ctrl = 3'b000;
        n.rd = 5'd0;
      end
    end
    return n;
  endfunction

  function automatic d_t rand_d();
    d_t d;
    d.reg_write = 1'($urandom); d.result_src = 2'($urandom); d.mem_write = 1'($urandom);
    d.jump = 1'($urandom); d.branch = 1'($urandom); d.jalr = 1'($urandom);
    d.alu_control = 4'($urandom); d.alu_src = 1'($urandom); d.addr_ctrl = 3'($urandom);
    d.rd1 = $urandom; d.rd2 = $urandom; d.pc = $urandom; d.imm = $urandom; d.pc4 = $urandom;
    d.rs1 = 5'($urandom); d.rs2 = 5'($urandom); d.rd = 5'($urandom);
    d.valid = ($urandom_range(0, 3) != 0);
    return d;
  endfunction

  // Drives control for one edge with the current d_in, queues the prediction, waits past the edge.
  task automatic step(input logic r, input logic s, input logic f);
    rst = r; stall = s; flush = f;
    mdl = model_next(mdl, r, s, f, d_in);
    sb.push_back(mdl);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    d_in = rand_d();
    step(1'b1, 1'b0, 1'b0);
    exp_e = sb.pop_front(); got_e = sample();
    checks++;
    if (got_e !== exp_e) begin
      errors++; $display("FAIL reset_state: got %h expected %h", got_e, exp_e);
    end
    checks++;
    if (got_e !== e_t'(0)) begin
      errors++; $display("FAIL reset_all_zero: got %h expected 0", got_e);
    end
  endtask

  task automatic test_load();
    d_in = '0;
    d_in.valid = 1'b1; d_in.reg_write = 1'b1; d_in.alu_control = 4'b0001;
    d_in.rd1 = 32'h0000_00AA; d_in.rd = 5'd5;
    step(1'b0, 1'b0, 1'b0);
    exp_e = sb.pop_front(); got_e = sample();
    checks++;
    if (got_e !== exp_e) begin
      errors++; $display("FAIL load: got %h expected %h", got_e, exp_e);
    end
    checks++;
    if ({e_reg_write, e_alu_control, e_rd1, e_rd, e_valid} !== {1'b1, 4'b0001, 32'hAA, 5'd5, 1'b1}) begin
      errors++;
      $display("FAIL load_fields: got rw=%b alu=%b rd1=%h rd=%0d v=%b expected rw=1 alu=0001 rd1=aa rd=5 v=1",
               e_reg_write, e_alu_control, e_rd1, e_rd, e_valid);
    end
  endtask

  task automatic test_stall();
    held = sample();
    for (int i = 0; i < 3; i++) begin
      d_in = rand_d();
      d_in.valid = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      exp_e = sb.pop_front(); got_e = sample();
      checks++;
      if (got_e !== exp_e) begin
        errors++; $display("FAIL stall_%0d: got %h expected %h", i, got_e, exp_e);
      end
    end
    got_e = sample();
    checks++;
    if (got_e.stl !== 32'd3) begin
      errors++; $display("FAIL stall_count: got %0d expected 3", got_e.stl);
    end
    got_e.stl = held.stl;
    checks++;
    if (got_e !== held) begin
      errors++; $display("FAIL stall_hold: got %h expected %h", got_e, held);
    end
  endtask

  task automatic test_flush();
    d_in = rand_d();
    d_in.valid = 1'b1; d_in.mem_write = 1'b1; d_in.rd = 5'd9;
    step(1'b0, 1'b0, 1'b0);
    exp_e = sb.pop_front(); got_e = sample();
    checks++;
    if (got_e !== exp_e || e_mem_write !== 1'b1) begin
      errors++; $display("FAIL flush_preload: got %h expected %h", got_e, exp_e);
    end
    d_in = rand_d();
    step(1'b0, 1'b1, 1'b1);
    exp_e = sb.pop_front(); got_e = sample();
    checks++;
    if (got_e !== exp_e) begin
      errors++; $display("FAIL flush_stall: got %h expected %h", got_e, exp_e);
    end
    checks++;
    if ({e_mem_write, e_valid, e_rd, e_bub, e_stl} !== {1'b0, 1'b0, 5'd0, 32'd1, 32'd3}) begin
      errors++;
      $display("FAIL flush_fields: got mw=%b v=%b rd=%0d bub=%0d stl=%0d expected mw=0 v=0 rd=0 bub=1 stl=3",
               e_mem_write, e_valid, e_rd, e_bub, e_stl);
    end
  endtask

  task automatic test_invalid();
    d_in = rand_d();
    d_in.valid = 1'b0; d_in.reg_write = 1'b1; d_in.mem_write = 1'b1; d_in.rd = 5'd7;
    step(1'b0, 1'b0, 1'b0);
    exp_e = sb.pop_front(); got_e = sample();
    checks++;
    if (got_e !== exp_e) begin
      errors++; $display("FAIL invalid: got %h expected %h", got_e, exp_e);
    end
    checks++;
    if ({e_reg_write, e_mem_write, e_rd, e_valid, e_rd1} !== {1'b0, 1'b0, 5'd0, 1'b0, d_in.rd1}) begin
      errors++;
      $display("FAIL invalid_fields: got rw=%b mw=%b rd=%0d v=%b rd1=%h expected 0 0 0 0 rd1=%h",
               e_reg_write, e_mem_write, e_rd, e_valid, e_rd1, d_in.rd1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      d_in = rand_d();
      step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      exp_e = sb.pop_front(); got_e = sample();
      checks++;
      if (got_e !== exp_e) begin
        errors++; $display("FAIL b2b_%0d: got %h expected %h", i, got_e, exp_e);
      end
      checks++;
      if (!e_valid && {e_reg_write, e_mem_write, e_jump, e_branch, e_jalr, e_result_src,
                       e_alu_control, e_alu_src, e_addr_ctrl, e_rd} !== '0) begin
        errors++; $display("FAIL b2b_bubble_ctrl_%0d: control nonzero while ValidE=0", i);
      end
    end
  endtask

  task automatic test_saturation();
    force dut.BubbleCountE = 32'hFFFF_FFFE;
    force dut.StallCountE  = 32'hFFFF_FFFE;
    #1;
    release dut.BubbleCountE;
    release dut.StallCountE;
    #1;
    mdl.bub = 32'hFFFF_FFFE;
    mdl.stl = 32'hFFFF_FFFE;
    checks++;
    if (e_bub !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL sat_preset: got %h expected fffffffe", e_bub);
    end
    for (int i = 0; i < 3; i++) begin
      d_in = rand_d();
      step(1'b0, 1'b0, 1'b1);
      exp_e = sb.pop_front(); got_e = sample();
      checks++;
      if (got_e !== exp_e || e_bub !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL bubble_sat_%0d: got bub=%h expected ffffffff", i, e_bub);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0);
      exp_e = sb.pop_front(); got_e = sample();
      checks++;
      if (got_e !== exp_e || e_stl !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL stall_sat_%0d: got stl=%h expected ffffffff", i, e_stl);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    d_in = rand_d();
    d_in.valid = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(1'b0, 1'b1, 1'b0);
    void'(sb.pop_front());
    step(1'b1, 1'b1, 1'b1);
    exp_e = sb.pop_front(); got_e = sample();
    checks++;
    if (got_e !== exp_e || got_e !== e_t'(0)) begin
      errors++; $display("FAIL reset_mid_stall: got %h expected 0", got_e);
    end
    d_in = rand_d();
    d_in.valid = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    exp_e = sb.pop_front(); got_e = sample();
    checks++;
    if (got_e !== exp_e) begin
      errors++; $display("FAIL load_after_reset: got %h expected %h", got_e, exp_e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_invalid();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
